// File: rtl/cp_read_scheduler_pkg.sv
// Shared constants, FSM state type and CP-length helpers for the CP read scheduler.
package cp_pkg;
    localparam int IFFT_SIZE   = 2048;
    localparam int N_SYMB      = 14;
    localparam int NCP_LONG    = 160;
    localparam int NCP_SHORT   = 144;
    localparam int LONG_PERIOD = 7;
    localparam int ADDR_W      = $clog2(IFFT_SIZE);
    localparam int SYM_W       = 4;

    typedef enum logic [1:0] {IDLE, WAIT_SYM, CP, BODY} cp_state_t;

    function automatic logic [ADDR_W-1:0] cp_len(input logic [SYM_W-1:0] sym_idx);
        return (sym_idx == '0 || sym_idx == SYM_W'(LONG_PERIOD)) ? ADDR_W'(NCP_LONG)
                                                                 : ADDR_W'(NCP_SHORT);
    endfunction

    // First CP address: the CP is the tail of the bank.
    function automatic logic [ADDR_W-1:0] cp_start(input logic [SYM_W-1:0] sym_idx);
        return ADDR_W'(IFFT_SIZE - int'(cp_len(sym_idx)));
    endfunction
endpackage

// File: rtl/cp_read_scheduler_if.sv
// Writer-bank handshake and read-beat bus of the CP read scheduler.
interface cp_read_scheduler_if;
    import cp_pkg::*;

    logic              sym_ready;
    logic              sym_bank;
    logic              sym_release;
    logic              rel_bank;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_first;
    logic              rd_last;
    logic              rd_cp;

    modport master (
        input  sym_ready, sym_bank, rd_ready,
        output sym_release, rel_bank, rd_valid, rd_bank, rd_addr, rd_first, rd_last, rd_cp
    );

    modport slave (
        output sym_ready, sym_bank, rd_ready,
        input  sym_release, rel_bank, rd_valid, rd_bank, rd_addr, rd_first, rd_last, rd_cp
    );
endinterface

// File: rtl/cp_read_scheduler_addr_gen.sv
// Loadable bank address counter: advances on accepted beats, wraps naturally at IFFT_SIZE.
module cp_addr_gen
    import cp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              adv_i,
    input  logic              body_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              at_cp_end_o,
    output logic              at_body_end_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              at_max;

    always_comb begin
        // NOTE: default first so every path assigns addr_d and no latch is inferred.
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (adv_i) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign at_max        = (addr_q == '1);
    assign at_cp_end_o   = at_max & ~body_i;
    assign at_body_end_o = at_max & body_i;
    assign addr_o        = addr_q;
endmodule

// File: rtl/cp_read_scheduler.sv
// Reads a filled ping-pong bank back as a CP-prefixed symbol stream and tracks the slot.
// Optional statistics counters are enabled with the CP_SCHED_STATS_EN macro.
module cp_read_scheduler
    import cp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clr_err,
    cp_read_scheduler_if.master bus,
    output logic [SYM_W-1:0]  sym_idx,
    output logic              busy,
    output logic              err_underrun
`ifdef CP_SCHED_STATS_EN
    ,
    output logic [15:0]       stat_syms,
    output logic [15:0]       stat_slots
`endif
);
    cp_state_t         state_q;
    logic [SYM_W-1:0]  sym_idx_q, idx_inc;
    logic              rd_bank_q, rel_bank_q, sym_release_q, first_q, prev_vld_q, err_q;
    logic              xfer, in_body, at_cp_end, at_body_end;
    logic              bank_ok, b2b_ok, end_sym, start_wait, start_b2b, load;
    logic [ADDR_W-1:0] addr, load_val;

    assign bus.rd_valid = (state_q == CP) || (state_q == BODY);
    assign xfer         = bus.rd_valid & bus.rd_ready;
    assign in_body      = (state_q == BODY);
    assign idx_inc      = (sym_idx_q == SYM_W'(N_SYMB - 1)) ? '0 : sym_idx_q + SYM_W'(1);

    // A bank equal to the one just read is stale; the first symbol after IDLE takes any bank.
    assign b2b_ok     = bus.sym_ready && (bus.sym_bank != rd_bank_q);
    assign bank_ok    = bus.sym_ready && (!prev_vld_q || (bus.sym_bank != rd_bank_q));
    assign end_sym    = in_body && xfer && at_body_end;
    assign start_wait = (state_q == WAIT_SYM) && enable && bank_ok;
    assign start_b2b  = end_sym && enable && b2b_ok;
    assign load       = start_wait | start_b2b;
    assign load_val   = cp_start(start_b2b ? idx_inc : sym_idx_q);

    cp_addr_gen u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .load_val_i   (load_val),
        .adv_i        (xfer),
        .body_i       (in_body),
        .addr_o       (addr),
        .at_cp_end_o  (at_cp_end),
        .at_body_end_o(at_body_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sym_idx_q     <= '0;
            rd_bank_q     <= 1'b0;
            rel_bank_q    <= 1'b0;
            sym_release_q <= 1'b0;
            first_q       <= 1'b0;
            prev_vld_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sym_release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sym_idx_q  <= '0;
                    prev_vld_q <= 1'b0;
                    if (enable) state_q <= WAIT_SYM;
                end
                WAIT_SYM: begin
                    if (!enable) begin
                        state_q   <= IDLE;
                        sym_idx_q <= '0;
                    end else if (bank_ok) begin
                        state_q   <= CP;
                        rd_bank_q <= bus.sym_bank;
                        first_q   <= 1'b1;
                    end
                end
                CP: begin
                    if (xfer) begin
                        first_q <= 1'b0;
                        if (at_cp_end) state_q <= BODY;
                    end
                end
                BODY: begin
                    if (end_sym) begin
                        sym_release_q <= 1'b1;
                        rel_bank_q    <= rd_bank_q;
                        prev_vld_q    <= 1'b1;
                        if (!enable) begin
                            state_q   <= IDLE;
                            sym_idx_q <= '0;
                        end else begin
                            sym_idx_q <= idx_inc;
                            if (b2b_ok) begin
                                state_q   <= CP;
                                rd_bank_q <= bus.sym_bank;
                                first_q   <= 1'b1;
                            end else begin
                                state_q <= WAIT_SYM;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Set wins over clear when both happen in the same cycle.
            if ((state_q == WAIT_SYM) && (sym_idx_q != '0) && !bank_ok) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

`ifdef CP_SCHED_STATS_EN
    logic [15:0] stat_syms_q, stat_slots_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_syms_q  <= '0;
            stat_slots_q <= '0;
        end else if (end_sym) begin
            stat_syms_q <= stat_syms_q + 16'd1;
            if (sym_idx_q == SYM_W'(N_SYMB - 1)) stat_slots_q <= stat_slots_q + 16'd1;
        end
    end

    assign stat_syms  = stat_syms_q;
    assign stat_slots = stat_slots_q;
`endif

    assign bus.sym_release = sym_release_q;
    assign bus.rel_bank    = rel_bank_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.rd_addr     = addr;
    assign bus.rd_first    = first_q;
    assign bus.rd_last     = in_body && at_body_end;
    assign bus.rd_cp       = (state_q == CP);
    assign sym_idx         = sym_idx_q;
    assign busy            = (state_q != IDLE);
    assign err_underrun    = err_q;
endmodule
